// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: per-channel memory handshake FSMs that freeze the PC/pipeline enables until every
// outstanding memory op completes. Define MEM_STALL_TIMEOUT_EN to add a per-channel abort timer.
module mem_stall_ctrl #(
  parameter int NCH    = 2,
  parameter int NSTG   = 5,
  parameter int DATA_W = 32,
  parameter int TOUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        req_i,
  input  logic [NCH-1:0]        done_i,
  input  logic [NCH*DATA_W-1:0] rdata_i,
  input  logic [NSTG-1:0]       en_i,
  output logic [NCH-1:0]        cmd_o,
  output logic [NCH*DATA_W-1:0] rdata_o,
  output logic [NSTG-1:0]       en_o,
  output logic                  busy_o,
  output logic [NCH-1:0]        err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  logic [NCH-1:0] in_wait;
  logic [NCH-1:0] idle_req;
  logic           release_cyc;
  logic           stall;

  // A release cycle is one where nobody is still waiting; only then may finished channels retire.
  assign release_cyc = ~|in_wait;
  assign stall       = (|in_wait) | (|idle_req);
  assign busy_o      = |in_wait;
  assign en_o        = en_i & {NSTG{~stall}};

`ifdef MEM_STALL_TIMEOUT_EN
  // Abort on the edge where the counter would reach all-ones, i.e. after 2^TOUT_W-1 WAIT cycles.
  localparam logic [TOUT_W-1:0] TOUT_LAST = {TOUT_W{1'b1}} - TOUT_W'(1);
`else
  logic [TOUT_W-1:0] unused_tout;
  assign unused_tout = '0;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] rdata_q;
    logic              abort;

    assign in_wait[c]  = (state_q == WAIT);
    assign idle_req[c] = (state_q == IDLE) && req_i[c];
    assign cmd_o[c]    = (state_q == WAIT);
    assign rdata_o[c*DATA_W +: DATA_W] = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
    end

    // DONE deliberately ignores req_i so a request still held by the frozen instruction is not reissued.
    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:    if (req_i[c]) state_d = WAIT;
        WAIT:    if (done_i[c] || abort) state_d = DONE;
        DONE:    if (release_cyc) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else if (state_q == WAIT) begin
        if (done_i[c])  rdata_q <= rdata_i[c*DATA_W +: DATA_W];
        else if (abort) rdata_q <= '0;
      end
    end

`ifdef MEM_STALL_TIMEOUT_EN
    logic [TOUT_W-1:0] cnt_q;
    logic              err_q;

    assign abort    = (state_q == WAIT) && !done_i[c] && (cnt_q == TOUT_LAST);
    assign err_o[c] = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        if (state_q == IDLE && req_i[c]) cnt_q <= '0;
        else if (state_q == WAIT)        cnt_q <= cnt_q + TOUT_W'(1);
        if (abort) err_q <= 1'b1;
      end
    end
`else
    assign abort    = 1'b0;
    assign err_o[c] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: scoreboard bench for mem_stall_ctrl (default build, timeout disabled).
// Expected read data is queued when a completing done_i is driven and checked when cmd_o falls.
module tb_mem_stall_ctrl;

  localparam int NCH    = 2;
  localparam int NSTG   = 5;
  localparam int DATA_W = 32;
  localparam int TOUT_W = 8;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NCH-1:0]        req_i = '0;
  logic [NCH-1:0]        done_i = '0;
  logic [NCH*DATA_W-1:0] rdata_i = '0;
  logic [NSTG-1:0]       en_i = 5'b11111;
  logic [NCH-1:0]        cmd_o;
  logic [NCH*DATA_W-1:0] rdata_o;
  logic [NSTG-1:0]       en_o;
  logic                  busy_o;
  logic [NCH-1:0]        err_o;

  int checkCount = 0;
  int failCount  = 0;

  logic [31:0] expQ0[$];
  logic [31:0] expQ1[$];
  logic [1:0]  prevCmd = '0;
  int          riseCount0 = 0;
  int          riseCount1 = 0;
  int          riseBase;

  mem_stall_ctrl #(.NCH(NCH), .NSTG(NSTG), .DATA_W(DATA_W), .TOUT_W(TOUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .done_i(done_i), .rdata_i(rdata_i), .en_i(en_i),
    .cmd_o(cmd_o), .rdata_o(rdata_o), .en_o(en_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge.
  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] done,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [4:0] en);
    @(posedge clk);
    #1;
    req_i   = req;
    done_i  = done;
    rdata_i = {d1, d0};
    en_i    = en;
  endtask

  task automatic expectCycle(input string tag, input logic [1:0] cmd, input logic [4:0] en, input logic busy);
    @(negedge clk);
    checkOutput({tag, "_cmd"}, cmd_o, cmd);
    checkOutput({tag, "_en"}, en_o, en);
    checkOutput({tag, "_busy"}, busy_o, busy);
  endtask

  // Scoreboard side: a falling cmd_o marks a completed op whose latched data must match the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevCmd = '0;
    end else begin
      if (!prevCmd[0] && cmd_o[0]) riseCount0++;
      if (!prevCmd[1] && cmd_o[1]) riseCount1++;
      if (prevCmd[0] && !cmd_o[0]) begin
        if (expQ0.size() == 0) checkOutput("sb_ch0_unexpected", 1, 0);
        else                   checkOutput("sb_ch0_rdata", rdata_o[31:0], expQ0.pop_front());
      end
      if (prevCmd[1] && !cmd_o[1]) begin
        if (expQ1.size() == 0) checkOutput("sb_ch1_unexpected", 1, 0);
        else                   checkOutput("sb_ch1_rdata", rdata_o[63:32], expQ1.pop_front());
      end
      prevCmd = cmd_o;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #1;
    checkOutput("rst_cmd", cmd_o, 2'b00);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_rdata", rdata_o, 64'h0);
    checkOutput("rst_err", err_o, 2'b00);
    checkOutput("rst_en", en_o, 5'b11111);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single read on channel 1
    applyStimulus(2'b10, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t1_c0", 2'b00, 5'b00000, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(2'b10, 2'b00, JUNK, JUNK, 5'b11111);
      expectCycle("t1_wait", 2'b10, 5'b00000, 1'b1);
    end
    expQ1.push_back(32'hDEADBEEF);
    applyStimulus(2'b10, 2'b10, JUNK, 32'hDEADBEEF, 5'b11111);
    expectCycle("t1_c4", 2'b10, 5'b00000, 1'b1);
    applyStimulus(2'b10, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t1_c5", 2'b00, 5'b11111, 1'b0);
    checkOutput("t1_rdata1", rdata_o[63:32], 32'hDEADBEEF);
    applyStimulus(2'b00, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t1_c6", 2'b00, 5'b11111, 1'b0);
    checkOutput("t1_pulses", riseCount1, 1);

    // Dual channel, channel 0 finishes early and holds
    applyStimulus(2'b11, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t2_c0", 2'b00, 5'b00000, 1'b0);
    applyStimulus(2'b11, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t2_c1", 2'b11, 5'b00000, 1'b1);
    expQ0.push_back(32'hA5A5_0001);
    applyStimulus(2'b11, 2'b01, 32'hA5A5_0001, JUNK, 5'b11111);
    expectCycle("t2_c2", 2'b11, 5'b00000, 1'b1);
    for (int i = 3; i <= 5; i++) begin
      applyStimulus(2'b11, 2'b00, JUNK, JUNK, 5'b11111);
      expectCycle("t2_hold", 2'b10, 5'b00000, 1'b1);
    end
    expQ1.push_back(32'h5A5A_0002);
    applyStimulus(2'b11, 2'b10, JUNK, 32'h5A5A_0002, 5'b11111);
    expectCycle("t2_c6", 2'b10, 5'b00000, 1'b1);
    applyStimulus(2'b11, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t2_c7", 2'b00, 5'b11111, 1'b0);
    applyStimulus(2'b00, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t2_c8", 2'b00, 5'b11111, 1'b0);
    checkOutput("t2_rdata", rdata_o, {32'h5A5A_0002, 32'hA5A5_0001});

    // No reissue while held; reissue after drop; en_i=0 does not cancel WAIT
    riseBase = riseCount0;
    applyStimulus(2'b01, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t3_c0", 2'b00, 5'b00000, 1'b0);
    applyStimulus(2'b01, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t3_c1", 2'b01, 5'b00000, 1'b1);
    expQ0.push_back(32'h1357_9BDF);
    applyStimulus(2'b01, 2'b01, 32'h1357_9BDF, JUNK, 5'b11111);
    expectCycle("t3_c2", 2'b01, 5'b00000, 1'b1);
    applyStimulus(2'b01, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t3_rel", 2'b00, 5'b11111, 1'b0);
    applyStimulus(2'b00, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t3_drop", 2'b00, 5'b11111, 1'b0);
    checkOutput("t3_one_pulse", riseCount0 - riseBase, 1);
    applyStimulus(2'b01, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t3_req2", 2'b00, 5'b00000, 1'b0);
    applyStimulus(2'b01, 2'b00, JUNK, JUNK, 5'b00000);
    expectCycle("t3_dbg0", 2'b01, 5'b00000, 1'b1);
    applyStimulus(2'b01, 2'b00, JUNK, JUNK, 5'b00000);
    expectCycle("t3_dbg1", 2'b01, 5'b00000, 1'b1);
    expQ0.push_back(32'h2468_ACE0);
    applyStimulus(2'b01, 2'b01, 32'h2468_ACE0, JUNK, 5'b11111);
    expectCycle("t3_done2", 2'b01, 5'b00000, 1'b1);
    applyStimulus(2'b00, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t3_rel2", 2'b00, 5'b11111, 1'b0);
    checkOutput("t3_two_pulses", riseCount0 - riseBase, 2);

    // Simultaneous req and done in IDLE: request wins, done ignored
    applyStimulus(2'b10, 2'b10, JUNK, 32'hFFFF_0000, 5'b11111);
    expectCycle("t5_c0", 2'b00, 5'b00000, 1'b0);
    applyStimulus(2'b10, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t5_c1", 2'b10, 5'b00000, 1'b1);
    checkOutput("t5_rdata_held", rdata_o[63:32], 32'h5A5A_0002);
    expQ1.push_back(32'h0BAD_F00D);
    applyStimulus(2'b10, 2'b10, JUNK, 32'h0BAD_F00D, 5'b11111);
    expectCycle("t5_c2", 2'b10, 5'b00000, 1'b1);
    applyStimulus(2'b00, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t5_rel", 2'b00, 5'b11111, 1'b0);

    // Reset in the middle of WAIT
    applyStimulus(2'b10, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t4_c0", 2'b00, 5'b00000, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      applyStimulus(2'b10, 2'b00, JUNK, JUNK, 5'b11111);
      expectCycle("t4_wait", 2'b10, 5'b00000, 1'b1);
    end
    applyStimulus(2'b10, 2'b00, JUNK, JUNK, 5'b11111);
    #2;
    rst_n = 1'b0;
    req_i = 2'b00;
    #1;
    checkOutput("t4_rst_cmd", cmd_o, 2'b00);
    checkOutput("t4_rst_busy", busy_o, 1'b0);
    checkOutput("t4_rst_rdata", rdata_o, 64'h0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(2'b00, 2'b10, JUNK, 32'hCAFE_F00D, 5'b11111);
    expectCycle("t4_post", 2'b00, 5'b11111, 1'b0);
    applyStimulus(2'b00, 2'b00, JUNK, JUNK, 5'b11111);
    expectCycle("t4_post2", 2'b00, 5'b11111, 1'b0);
    checkOutput("t4_no_done_data", rdata_o[63:32], 32'h0);

    // Stray done in IDLE and en_i passthrough with no request
    applyStimulus(2'b00, 2'b01, 32'h1234_5678, JUNK, 5'b00000);
    expectCycle("t6_c0", 2'b00, 5'b00000, 1'b0);
    applyStimulus(2'b00, 2'b00, JUNK, JUNK, 5'b10101);
    expectCycle("t6_c1", 2'b00, 5'b10101, 1'b0);
    checkOutput("t6_rdata0", rdata_o[31:0], 32'h0);
    checkOutput("t6_err", err_o, 2'b00);

    checkOutput("sb_drain0", expQ0.size(), 0);
    checkOutput("sb_drain1", expQ1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
